imem_loader: RTL

// - Byte-stream program loader: receives a framed program image and writes it word-by-word into instruction memory.
// - Holds the pipelined core in reset until the image has loaded and its checksum has passed; then releases the core.
// - Sits between the host byte source (bench or UART RX) and the imem write port.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_word_asm.sv | 41 ++++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and frame constants for the byte-stream program loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_CSUM,
      S_HALT,
      S_DONE,
      S_ERR
   } state_e;

   localparam logic [31:0] HALT_WORD = 32'h0000_0000;
   localparam int          HDR_BYTES = 2;

endpackage

// File: rtl/imem_loader_word_asm.sv
// Little-endian byte-to-word assembler: three bytes are held, the fourth completes the word
// combinationally so the caller can register the imem write in the same cycle it is accepted.
module imem_loader_word_asm
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word_data
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] shift_q, shift_d;

   always_comb begin
      // NOTE: every variable gets a default before any branch; a path that leaves one unassigned infers a latch.
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (byte_valid) begin
         cnt_d   = cnt_q + 2'd1;
         shift_d = {byte_data, shift_q[23:8]};
      end
   end

   assign word_valid = byte_valid && (cnt_q == 2'd3);
   assign word_data  = {byte_data, shift_q};

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
      if (!reset) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: LEN0 LEN1 | N little-endian words | XOR checksum, written into imem.
// Define IMEM_LOADER_HALT_WORD_EN to append a zero halt word at BASE_ADDR+N after a good load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   localparam logic [31:0]           MAX_WORDS = 32'(1) << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

   state_e                state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [7:0]            csum_q, csum_d;
   logic [ADDR_WIDTH:0]   k_q, k_d;
   logic                  in_ready_q, in_ready_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic                  accept;
   logic                  asm_valid;
   logic                  word_valid;
   logic [31:0]           word_data;
   logic [15:0]           len_full;

   assign accept    = in_valid && in_ready_q;
   assign asm_valid = accept && (state_q == S_DATA);
   assign len_full  = {in_data, len_q[7:0]};

   imem_loader_word_asm u_word_asm (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (asm_valid),
      .byte_data  (in_data),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      csum_d       = csum_q;
      k_d          = k_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      cpu_reset_d  = cpu_reset_q;
      done_d       = done_q;
      error_d      = error_q;

      case (state_q)
         S_LEN0: if (accept) begin
            len_d[7:0] = in_data;
            csum_d     = csum_q ^ in_data;
            state_d    = S_LEN1;
         end
         S_LEN1: if (accept) begin
            len_d[15:8] = in_data;
            csum_d      = csum_q ^ in_data;
            if (32'(len_full) > MAX_WORDS) begin
               state_d = S_ERR;
               error_d = 1'b1;
            end else if (len_full == 16'd0) begin
               state_d = S_CSUM;
            end else begin
               state_d = S_DATA;
            end
         end
         S_DATA: if (accept) begin
            csum_d = csum_q ^ in_data;
            if (word_valid) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = BASE + k_q[ADDR_WIDTH-1:0];
               imem_wdata_d = word_data;
               k_d          = k_q + 1'b1;
               if ((32'(k_q) + 32'd1) == 32'(len_q)) state_d = S_CSUM;
            end
         end
         S_CSUM: if (accept) begin
            if (in_data != csum_q) begin
               state_d = S_ERR;
               error_d = 1'b1;
`ifdef IMEM_LOADER_HALT_WORD_EN
            end else if (!k_q[ADDR_WIDTH]) begin
               // k equals N here, so its top bit is set only when N == MAX_WORDS.
               imem_we_d    = 1'b1;
               imem_addr_d  = BASE + k_q[ADDR_WIDTH-1:0];
               imem_wdata_d = HALT_WORD;
               state_d      = S_HALT;
`endif
            end else begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               cpu_reset_d = 1'b0;
            end
         end
`ifdef IMEM_LOADER_HALT_WORD_EN
         S_HALT: begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
         end
`endif
         default: ;
      endcase

      in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                   (state_d == S_DATA) || (state_d == S_CSUM);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_LEN0;
         len_q        <= '0;
         csum_q       <= '0;
         k_q          <= '0;
         in_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_reset_q  <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         csum_q       <= csum_d;
         k_q          <= k_d;
         in_ready_q   <= in_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_reset_q  <= cpu_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule
